mv_pred_decoder: RTL and testbench

Multi-predictor motion-vector decoder for the MPEG video path. It holds a bank of signed motion-vector predictors (PMVs) and accepts one (motion_code, motion_residual) pair per transaction for a selected predictor and component. Per transaction it decodes the delta, applies full-pel and field-vertical scaling, wraps the result into range, returns the new vector and writes it back. It sits between the macroblock VLC parser and motion compensation, and replaces the single-shot, fixed-r_size decoder.

---
 rtl/mv_pred_decoder.sv | 162 ++++++++++++++++
 tb/tb_mv_pred_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mv_pred_decoder.sv
// MPEG motion-vector predictor bank: decode delta, scale, wrap, write back; 2 cycles accept-to-result.
// One transaction in flight; in_ready only in IDLE, result held in HOLD until out_ready.
module mv_pred_decoder #(
  parameter int NUM_PMV = 4,
  parameter int DATA_W  = 16,
  parameter int SEL_W   = $clog2(NUM_PMV)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [SEL_W-1:0]  i_pmv_sel,
  input  logic              i_comp,
  input  logic [3:0]        i_f_code,
  input  logic [4:0]        i_motion_code,
  input  logic [7:0]        i_motion_residual,
  input  logic              i_full_pel,
  input  logic              i_field_vert,
  input  logic              i_dup,
  input  logic              i_pmv_clear,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_vec,
  output logic              o_out_err
);
  localparam int AW = DATA_W + 3;
  localparam logic signed [AW-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, DELTA, WRAP, HOLD} state_t;

  state_t                    r_state, w_next;
  logic signed [DATA_W-1:0]  r_pmv [NUM_PMV][2];

  logic [SEL_W-1:0]          r_sel;
  logic                      r_comp, r_full_pel, r_field_vert, r_dup;
  logic [3:0]                r_fcode;
  logic signed [4:0]         r_mc;
  logic [7:0]                r_res;
  logic signed [DATA_W-1:0]  r_p;
  logic signed [AW-1:0]      r_ps, r_delta;
  logic [DATA_W-1:0]         r_out_vec;
  logic                      r_out_err;

  logic signed [DATA_W-1:0]  w_p;
  logic [3:0]                w_rsize;
  logic                      w_illegal, w_shift;
  logic signed [AW-1:0]      w_p_ext, w_ps, w_delta, w_lim, w_v0, w_v;
  logic [4:0]                w_mc_abs;
  logic [7:0]                w_res_m;
  logic [AW-1:0]             w_mag;
  logic signed [DATA_W-1:0]  w_r;
  logic [SEL_W-1:0]          w_dup_sel;

  // A clear in the accept cycle makes the predictor read as zero.
  assign w_p       = i_pmv_clear ? '0 : r_pmv[i_pmv_sel][i_comp];
  assign w_rsize   = r_fcode - 4'd1;
  assign w_illegal = (r_fcode == 4'd0) || (r_fcode > 4'd9);
  assign w_shift   = r_full_pel | (r_field_vert & r_comp);

  assign w_p_ext   = {{3{r_p[DATA_W-1]}}, r_p};
  assign w_ps      = w_shift ? (w_p_ext >>> 1) : w_p_ext;
  assign w_mc_abs  = r_mc[4] ? (~r_mc + 5'd1) : r_mc;
  assign w_res_m   = r_res & 8'((9'd1 << w_rsize) - 9'd1);
  assign w_mag     = ({{(AW-5){1'b0}}, w_mc_abs - 5'd1} << w_rsize)
                   + {{(AW-8){1'b0}}, w_res_m} + AW'(1);

  always_comb begin
    w_delta = {{(AW-5){r_mc[4]}}, r_mc};
    if (r_mc != 5'sd0 && w_rsize != 4'd0)
      w_delta = r_mc[4] ? -$signed(w_mag) : $signed(w_mag);
  end

  assign w_lim = $signed({{(AW-5){1'b0}}, 5'd16} << w_rsize);
  assign w_v0  = r_ps + r_delta;

  always_comb begin
    w_v = w_v0;
    if (w_v0 < -w_lim)
      w_v = w_v0 + (w_lim <<< 1);
    else if (w_v0 > w_lim - ONE)
      w_v = w_v0 - (w_lim <<< 1);
  end

  assign w_r       = DATA_W'(w_v <<< w_shift);
  assign w_dup_sel = r_sel ^ SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_in_valid) w_next = DELTA;
      DELTA:   w_next = WRAP;
      WRAP:    w_next = HOLD;
      HOLD:    if (i_out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= '0;
      r_comp       <= 1'b0;
      r_full_pel   <= 1'b0;
      r_field_vert <= 1'b0;
      r_dup        <= 1'b0;
      r_fcode      <= '0;
      r_mc         <= '0;
      r_res        <= '0;
      r_p          <= '0;
      r_ps         <= '0;
      r_delta      <= '0;
      r_out_vec    <= '0;
      r_out_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_in_valid) begin
          r_sel        <= i_pmv_sel;
          r_comp       <= i_comp;
          r_full_pel   <= i_full_pel;
          r_field_vert <= i_field_vert;
          r_dup        <= i_dup;
          r_fcode      <= i_f_code;
          r_mc         <= i_motion_code;
          r_res        <= i_motion_residual;
          r_p          <= w_p;
        end
        DELTA: begin
          r_ps    <= w_ps;
          r_delta <= w_delta;
        end
        WRAP: begin
          r_out_vec <= w_illegal ? r_p : w_r;
          r_out_err <= w_illegal;
        end
        HOLD: if (i_out_ready) r_out_err <= 1'b0;
        default: ;
      endcase
    end
  end

  // Clear beats a coincident write-back; the in-flight result is unaffected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || i_pmv_clear) begin
      for (int i = 0; i < NUM_PMV; i++)
        for (int j = 0; j < 2; j++)
          r_pmv[i][j] <= '0;
    end else if (r_state == WRAP && !w_illegal) begin
      r_pmv[r_sel][r_comp] <= w_r;
      if (r_dup && int'(w_dup_sel) < NUM_PMV)
        r_pmv[w_dup_sel][r_comp] <= w_r;
    end
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = (r_state == HOLD);
  assign o_out_vec   = r_out_vec;
  assign o_out_err   = r_out_err;
endmodule

// File: tb/tb_mv_pred_decoder.sv
module tb_mv_pred_decoder;
  localparam int NUM_PMV = 4;
  localparam int DATA_W  = 16;
  localparam int SEL_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_in_valid, o_in_ready;
  logic [SEL_W-1:0]  i_pmv_sel;
  logic              i_comp;
  logic [3:0]        i_f_code;
  logic [4:0]        i_motion_code;
  logic [7:0]        i_motion_residual;
  logic              i_full_pel, i_field_vert, i_dup, i_pmv_clear;
  logic              o_out_valid, i_out_ready;
  logic [DATA_W-1:0] o_out_vec;
  logic              o_out_err;

  mv_pred_decoder #(.NUM_PMV(NUM_PMV), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_pmv_sel(i_pmv_sel), .i_comp(i_comp), .i_f_code(i_f_code),
    .i_motion_code(i_motion_code), .i_motion_residual(i_motion_residual),
    .i_full_pel(i_full_pel), .i_field_vert(i_field_vert), .i_dup(i_dup),
    .i_pmv_clear(i_pmv_clear),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_vec(o_out_vec), .o_out_err(o_out_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int t_vec, t_err, t_lat, t_stable, t_rel, rv;
  bit seen_valid;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one transaction, waits (bounded) for the result, optionally stalls, then consumes it.
  task automatic txn(input int sel, input int comp, input int fc, input int mc, input int res,
                     input bit fp, input bit fv, input bit dp,
                     input bit clr_acc, input bit clr_wrap, input int hold);
    logic [DATA_W-1:0] held;
    @(negedge clk);
    i_in_valid = 1'b1;
    i_pmv_sel = SEL_W'(sel);
    i_comp = comp[0];
    i_f_code = 4'(fc);
    i_motion_code = 5'(mc);
    i_motion_residual = 8'(res);
    i_full_pel = fp;
    i_field_vert = fv;
    i_dup = dp;
    i_pmv_clear = clr_acc;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    i_pmv_clear = 1'b0;
    t_lat = 0;
    do begin
      @(posedge clk); #1;
      t_lat++;
      i_pmv_clear = clr_wrap && (t_lat == 1);
    end while (!o_out_valid && t_lat < 8);
    i_pmv_clear = 1'b0;
    held = o_out_vec;
    t_vec = int'($signed(o_out_vec));
    t_err = int'(o_out_err);
    t_stable = 1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (o_out_vec !== held || o_out_valid !== 1'b1 || o_in_ready !== 1'b0 ||
          int'(o_out_err) !== t_err)
        t_stable = 0;
    end
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    t_rel = (o_out_valid === 1'b0 && o_in_ready === 1'b1) ? 1 : 0;
  endtask

  // Moves a predictor from a known value to a target using f_code=9 (range +-4096).
  task automatic set_pmv(input int sel, input int comp, input int cur, input int tgt);
    int d;
    d = tgt - cur;
    txn(sel, comp, 9, (d > 0) ? 1 : -1, ((d > 0) ? d : -d) - 1, 0, 0, 0, 0, 0, 0);
    chk("set_pmv", t_vec, tgt);
  endtask

  task automatic rd(input int sel, input int comp, output int v);
    txn(sel, comp, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    v = t_vec;
  endtask

  initial begin
    rst_n = 1'b0;
    i_in_valid = 0; i_pmv_sel = 0; i_comp = 0; i_f_code = 0; i_motion_code = 0;
    i_motion_residual = 0; i_full_pel = 0; i_field_vert = 0; i_dup = 0;
    i_pmv_clear = 0; i_out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(o_in_ready), 1);
    chk("rst_out_valid", int'(o_out_valid), 0);
    chk("rst_out_vec", int'(o_out_vec), 0);
    chk("rst_out_err", int'(o_out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    set_pmv(0, 0, 0, 10);
    chk("lat_set", t_lat, 2);

    txn(0, 0, 2, 3, 1, 0, 0, 0, 0, 0, 0);
    chk("basic_vec", t_vec, 16);
    chk("basic_err", t_err, 0);
    chk("basic_lat", t_lat, 2);
    rd(0, 0, rv);
    chk("basic_wb", rv, 16);

    set_pmv(1, 0, 0, 30);
    txn(1, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0);
    chk("pos_wrap", t_vec, -31);

    set_pmv(2, 0, 0, -30);
    txn(2, 0, 2, -2, 1, 0, 0, 0, 0, 0, 0);
    chk("neg_wrap", t_vec, 30);

    set_pmv(3, 0, 0, 20);
    txn(3, 0, 1, -3, 0, 1, 0, 0, 0, 0, 0);
    chk("full_pel", t_vec, 14);
    rd(3, 0, rv);
    chk("full_pel_wb", rv, 14);

    set_pmv(3, 1, 0, -5);
    txn(3, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("field_vert_v", t_vec, -4);

    set_pmv(2, 0, 30, -5);
    txn(2, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("field_vert_h", t_vec, -4);

    txn(0, 0, 1, -9, 0, 0, 0, 1, 0, 0, 0);
    chk("dup_vec", t_vec, 7);
    rd(1, 0, rv);
    chk("dup_slot1", rv, 7);
    rd(1, 1, rv);
    chk("dup_other_comp", rv, 0);

    set_pmv(1, 0, 7, 9);
    txn(1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    chk("illegal0_vec", t_vec, 9);
    chk("illegal0_err", t_err, 1);
    chk("illegal0_lat", t_lat, 2);
    txn(1, 0, 10, 4, 0, 0, 0, 0, 0, 0, 0);
    chk("illegal10_vec", t_vec, 9);
    chk("illegal10_err", t_err, 1);
    rd(1, 0, rv);
    chk("illegal_nowb", rv, 9);
    chk("legal_err_clr", t_err, 0);

    txn(0, 0, 9, 1, 2, 0, 0, 0, 1, 0, 0);
    chk("clr_accept_vec", t_vec, 3);
    rd(1, 0, rv);
    chk("clr_accept_slot1", rv, 0);
    rd(3, 0, rv);
    chk("clr_accept_slot3", rv, 0);

    txn(2, 0, 9, 1, 4, 0, 0, 0, 0, 1, 0);
    chk("clr_wrap_vec", t_vec, 5);
    for (int s = 0; s < NUM_PMV; s++)
      for (int c = 0; c < 2; c++) begin
        rd(s, c, rv);
        chk($sformatf("clr_wrap_s%0d_c%0d", s, c), rv, 0);
      end

    txn(0, 0, 9, 1, 5, 0, 0, 0, 0, 0, 5);
    chk("bp_vec", t_vec, 6);
    chk("bp_stable", t_stable, 1);
    chk("bp_release", t_rel, 1);

    @(negedge clk);
    i_in_valid = 1'b1; i_pmv_sel = 0; i_comp = 0; i_f_code = 4'd9;
    i_motion_code = 5'd1; i_motion_residual = 8'd0;
    i_full_pel = 0; i_field_vert = 0; i_dup = 0;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    chk("pre_rst_in_ready", int'(o_in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(o_in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (o_out_valid === 1'b1) seen_valid = 1'b1;
    end
    chk("mid_rst_no_valid", int'(seen_valid), 0);
    chk("mid_rst_out_vec", int'(o_out_vec), 0);
    rd(0, 0, rv);
    chk("mid_rst_pmv", rv, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
